// File: rtl/mm_pkg.sv
// Constants shared between the game top level and its input front end.
// Debounce lengths for simulation and board, plus the colour switch width.
package mm_pkg;
    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 1000000;
    localparam int SW_W           = 3;

    // Counter must be able to hold DEBOUNCE_CYCLES-1 for any legal length.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a counter debouncer on a W-bit vector.
// A new level is accepted after DEBOUNCE_CYCLES identical samples that differ from it.
module debounce_bit
    import mm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int W               = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] level_o
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_len
        $error("debounce_bit: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [W-1:0]  sync1_q;
    logic [W-1:0]  sync2_q;
    logic [W-1:0]  level_q;
    logic [W-1:0]  level_d;
    logic [W-1:0]  cand_q;
    logic [W-1:0]  cand_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if ((cnt_q != '0) && (sync2_q != cand_q)) begin
            // A different non-level value mid-count becomes the candidate;
            // this sample is already its first.
            cand_d = sync2_q;
            cnt_d  = CW'(1);
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cand_d = sync2_q;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/input_conditioner.sv
// Cleans the two player buttons and the colour switches for the game core.
// Each accepted button press yields a single-cycle enter pulse; releases yield none.
module input_conditioner
    import mm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btnA_raw,
    input  logic            btnB_raw,
    input  logic [SW_W-1:0] sw_raw,
    output logic            enterA,
    output logic            enterB,
    output logic            btnA_level,
    output logic            btnB_level,
    output logic [SW_W-1:0] SW
);
    logic levelA_dly_q;
    logic levelB_dly_q;

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(1)) u_deb_a (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btnA_raw),
        .level_o (btnA_level)
    );

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(1)) u_deb_b (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btnB_raw),
        .level_o (btnB_level)
    );

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(SW_W)) u_deb_sw (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (sw_raw),
        .level_o (SW)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            levelA_dly_q <= 1'b0;
            levelB_dly_q <= 1'b0;
        end else begin
            levelA_dly_q <= btnA_level;
            levelB_dly_q <= btnB_level;
        end
    end

    assign enterA = btnA_level & ~levelA_dly_q;
    assign enterB = btnB_level & ~levelB_dly_q;
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that turns the raw board inputs (two player push-buttons and the 3-bit colour switch bank) into the clean signals the game core consumes. Each button passes through a 2-flop synchronizer, a counter-based debouncer and a rising-edge detector, producing exactly one single-cycle `enterA`/`enterB` pulse per physical press. The switch bank is synchronized and debounced as a vector, and `SW` changes only after a value has been stable. Outputs connect directly to the `enterA`, `enterB` and `SW` inputs of the game top level.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a new level. Use 4 in simulation and 1000000 (10 ms at 100 MHz) on the board. Must be ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- `btnA_raw`  in  1  asynchronous player-A button, high = pressed.
- `btnB_raw`  in  1  asynchronous player-B button, high = pressed.
- `sw_raw`  in  3  asynchronous colour switches.
- `enterA`  out  1  one-cycle pulse on an accepted A press.
- `enterB`  out  1  one-cycle pulse on an accepted B press.
- `btnA_level`  out  1  debounced A level.
- `btnB_level`  out  1  debounced B level.
- `SW`  out  3  debounced switch value.

## Operation
- **Synchronizers.** Each raw bit goes through two flops (`sync1` → `sync2`). Only `sync2` is used downstream.
- **Per-button debouncer.** State is `level` plus counter `cnt`, with width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync2 == level`, `cnt` is set to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1` and `sync2` still differs, `level` takes `sync2` and `cnt` returns to 0.
  - Any sample equal to `level` during counting clears `cnt`, so a glitch shorter than `DEBOUNCE_CYCLES` samples is discarded.
- **Edge detect.** `enterX` is 1 in the cycle in which `level` has just gone 0→1 (registered `level` and not registered `level_d`). Release (1→0) produces no pulse.
- **Buttons are independent.** Simultaneous A and B presses give simultaneous pulses. Arbitration belongs to the game core.
- **Switch debouncer.** This is the same algorithm applied to the 3-bit vector.
  - "Differs" means the vector is not equal to `SW`.
  - A candidate change must hold the same value for `DEBOUNCE_CYCLES` consecutive samples. If the value changes to another non-`SW` value mid-count, `cnt` restarts at 1 using the new candidate, which is held in register `sw_cand`.
- **Reset.** While `reset` is high, all sync flops, levels, counters, `sw_cand`, `level_d` and outputs are 0. Reset mid-debounce abandons the count with no pulse.
- **Button held through reset.** After reset deasserts, a held button is treated as a new press and produces one pulse `DEBOUNCE_CYCLES+2` cycles later. The game core tolerates this.
- **Counter saturation.** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, and there is no wrap-around.

## Timing
- Reset values: `enterA`=0, `enterB`=0, `btnA_level`=0, `btnB_level`=0, `SW`=3'b000.
- Press latency: raw high before edge 0 → `sync2` high after edge 1. The debouncer samples high at edges 2..D+1, so `level` and `enterX` are high after edge D+1, and `enterX` is low again after edge D+2. Here D = `DEBOUNCE_CYCLES`.
- `enterX` width: exactly 1 cycle, regardless of how long the button is held.
- Release latency: D+2 edges to `level` falling. No pulse on release.
- `SW` latency: D+2 edges from a stable raw change to the `SW` update.
- Minimum press/release spacing for distinct pulses: D samples low between presses.

## Structure
- **Shared package `mm_pkg`.** Holds `DEBOUNCE_SIM` = 4 and `DEBOUNCE_BOARD` = 1000000, so the game top and this block agree on the switch width constant `SW_W` = 3.
- **Sub-module `debounce_bit`.** Parameters `DEBOUNCE_CYCLES` and width `W`. Contains the synchronizer, counter, candidate and level logic. It is instantiated three times:
  - A with `W`=1,
  - B with `W`=1,
  - switches with `W`=3.
- **Top level.** Rising-edge pulse generation and port wiring only.

## Test plan
- **Clean press.** D=4, reset for 2 cycles, `btnA_raw`=1 from edge 0 → `enterA`=1 only in the cycle after edge 5. `btnA_level`=1 from edge 5 onward. `enterB` stays 0.
- **Glitch rejection.** `btnB_raw` high for 3 cycles then low → `enterB` and `btnB_level` stay 0 throughout.
- **Simultaneous press.** Both raws rise on the same edge → `enterA` and `enterB` pulse on the same cycle. A held press of 50 cycles gives no second pulse. Release followed by a re-press gives a second pulse.
- **Switch change.** `sw_raw` 000→101 held → `SW`=101 after edge D+1. Then toggle 101→110 for 2 cycles and back to 101 → `SW` stays 101.
- **Reset mid-debounce.** `btnA_raw` rises, `reset` is pulsed at edge 3 → no `enterA` before reset. With the button still held, one pulse is seen D+2 cycles after reset deasserts.
- **Release.** Press accepted, then raw falls → `btnA_level` falls D+2 edges later with no `enterA` pulse.
